ysyx_25040109_mdu: RTL

YSYX_25040109_MDU -- requirements
Module: ysyx_25040109_MDU

---
 rtl/ysyx_25040109_mdu.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040109_mdu.sv
// ysyx_25040109_mdu: RV M-extension multiply/divide unit.
// Uses a restoring divider at one bit per cycle. Multiplication is either an
// iterative shift-add or, with YSYX_25040109_MDU_FAST_MUL_EN defined, a
// single-cycle combinational product. Both builds give bit-identical results.
// A request is accepted at edge T. Fast paths (divide by zero, signed overflow,
// fast multiply) enter DONE at edge T, so out_valid is sampled high at edge T+1.
// Iterative paths finish their last step at edge T+XLEN, so out_valid is
// sampled high at edge T+XLEN+1.
module ysyx_25040109_mdu #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] tag_out,
    input  logic            flush
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t            state, state_d;
    logic [2:0]        op_q, op_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [CW-1:0]     cnt, cnt_d;
    // acc holds {remainder, quotient} for divide and {high, low} for multiply.
    logic [2*XLEN-1:0] acc, acc_d;
    // mcand holds the divisor magnitude or the multiplicand magnitude.
    logic [XLEN-1:0]   mcand, mcand_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              qneg, qneg_d;   // negate the quotient or the product
    logic              rneg, rneg_d;   // negate the remainder (dividend sign)

    // Operand decode at acceptance.
    logic            accept;
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    assign in_ready = (state == ST_IDLE) && !flush && !rst;
    assign accept   = in_valid && in_ready;
    assign is_div   = op[2];
    // MULH: both signed. MULHSU: src1 signed. MUL and MULHU: unsigned.
    // The low half of MUL does not depend on signedness.
    assign a_sgn    = is_div ? !op[0] : (op[1] ^ op[0]);
    assign b_sgn    = is_div ? !op[0] : (op[1:0] == 2'b01);
    assign a_neg    = a_sgn && src1[XLEN-1];
    assign b_neg    = b_sgn && src2[XLEN-1];
    assign a_mag    = a_neg ? -src1 : src1;
    assign b_mag    = b_neg ? -src2 : src2;
    assign div_zero = (src2 == '0);
    assign div_ovf  = !op[0] && (src1 == MOST_NEG) && (src2 == '1);

    // Shift-add step: add the multiplicand into the high half when the
    // multiplier LSB is set, then shift the whole accumulator right by one.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, mul_prod;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_step = {mul_sum, acc[XLEN-1:1]};
    assign mul_prod = qneg ? -mul_step : mul_step;
    assign mul_res  = (op_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // Restoring divide step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits.
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem, div_quo, div_res;
    logic [2*XLEN-1:0] div_step;

    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, mcand};
    assign div_rem   = div_ge ? (div_shift[XLEN-1:0] - mcand) : div_shift[XLEN-1:0];
    assign div_quo   = {acc[XLEN-2:0], div_ge};
    assign div_step  = {div_rem, div_quo};
    assign div_res   = op_q[1] ? (rneg ? -div_rem : div_rem)
                               : (qneg ? -div_quo : div_quo);

`ifdef YSYX_25040109_MDU_FAST_MUL_EN
    // Sign- or zero-extend both operands to 2*XLEN bits. The product
    // truncated to 2*XLEN bits is then exact.
    logic [2*XLEN-1:0] fa, fb, fprod;
    logic [XLEN-1:0]   fast_res;

    assign fa       = {{XLEN{a_neg}}, src1};
    assign fb       = {{XLEN{b_neg}}, src2};
    assign fprod    = fa * fb;
    assign fast_res = (op[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif

    logic last;
    assign last = (cnt == CW'(XLEN - 1));

    // Next-state and datapath logic; flush overrides every state.
    always_comb begin
        state_d = state;
        op_d    = op_q;
        tag_d   = tag_q;
        cnt_d   = cnt;
        acc_d   = acc;
        mcand_d = mcand;
        res_d   = res_q;
        qneg_d  = qneg;
        rneg_d  = rneg;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op;
                    tag_d = tag_in;
                    cnt_d = '0;
                    if (is_div) begin
                        if (div_zero) begin
                            res_d   = op[1] ? src1 : '1;
                            state_d = ST_DONE;
                        end else if (div_ovf) begin
                            res_d   = op[1] ? '0 : MOST_NEG;
                            state_d = ST_DONE;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, a_mag};
                            mcand_d = b_mag;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            state_d = ST_DIV;
                        end
                    end else begin
`ifdef YSYX_25040109_MDU_FAST_MUL_EN
                        res_d   = fast_res;
                        state_d = ST_DONE;
`else
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        mcand_d = a_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = 1'b0;
                        state_d = ST_MUL;
`endif
                    end
                end
            end
            ST_MUL: begin
                acc_d = mul_step;
                cnt_d = cnt + CW'(1);
                if (last) begin
                    res_d   = mul_res;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                acc_d = div_step;
                cnt_d = cnt + CW'(1);
                if (last) begin
                    res_d   = div_res;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            res_d   = '0;
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            op_q  <= '0;
            tag_q <= '0;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            res_q <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
        end else begin
            state <= state_d;
            op_q  <= op_d;
            tag_q <= tag_d;
            cnt   <= cnt_d;
            acc   <= acc_d;
            mcand <= mcand_d;
            res_q <= res_d;
            qneg  <= qneg_d;
            rneg  <= rneg_d;
        end
    end

    assign out_valid = (state == ST_DONE);
    assign result    = out_valid ? res_q : '0;
    assign tag_out   = tag_q;

endmodule
